// File: rtl/mem_port_arbiter.sv
// Purpose: shares one external memory bus between instruction fetch and the MEM stage; optional fetch anti-starvation via `ARB_FAIRNESS_EN.
// Latency: the grant is registered onto bus_* one cycle after arbitration, and the ack is combinational in the bus_ready cycle. One IDLE cycle separates transactions.
// Backpressure: requesters hold their request until acked. bus_* stay stable until bus_ready. A flushed fetch still completes on the bus, but its ack is suppressed.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [3:0]          bus_be_q, bus_be_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic                drop_q, drop_d;
    logic                if_elig;
    logic                force_if;

    // Fetch is word-aligned on the bus, so the low address bits are never forwarded.
    logic                unused_if_addr_lsb;
    assign unused_if_addr_lsb = ^if_addr[1:0];

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
`else
    logic                unused_starve_max;
    assign unused_starve_max = (STARVE_MAX > 0);
`endif

    assign if_elig = if_req && !if_flush;

    // Fetch is forced past MEM only after STARVE_MAX consecutive MEM wins.
`ifdef ARB_FAIRNESS_EN
    assign force_if = if_elig && (starve_cnt_q == CNT_W'(STARVE_MAX));
`else
    assign force_if = 1'b0;
`endif

    // Arbitration, bus register loading, completion routing and flush tracking.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        drop_d      = drop_q;
        if_ack      = 1'b0;
        mem_ack     = 1'b0;
        if_rdata    = bus_rdata;
        mem_rdata   = bus_rdata;
`ifdef ARB_FAIRNESS_EN
        starve_cnt_d = starve_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_req && !force_if) begin
                    state_d     = MEM_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_be_d    = mem_be;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
`ifdef ARB_FAIRNESS_EN
                    if (if_elig) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
`endif
                end else if (if_elig) begin
                    state_d    = IF_BUSY;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_be_d   = 4'hF;
                    bus_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
                    drop_d     = 1'b0;
`ifdef ARB_FAIRNESS_EN
                    starve_cnt_d = '0;
`endif
                end
`ifdef ARB_FAIRNESS_EN
                if (!if_req) begin
                    starve_cnt_d = '0;
                end
`endif
            end
            IF_BUSY: begin
                drop_d = drop_q || if_flush;
                if (bus_ready) begin
                    if_ack    = !drop_q && !if_flush;
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    drop_d    = 1'b0;
                end
            end
            MEM_BUSY: begin
                if (bus_ready) begin
                    mem_ack   = 1'b1;
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
        // A transaction cut short by reset must not complete towards the pipeline.
        if (rst) begin
            if_ack  = 1'b0;
            mem_ack = 1'b0;
        end
    end

    // State and bus registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'h0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'h0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            drop_q      <= drop_d;
        end
    end

`ifdef ARB_FAIRNESS_EN
    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: checks mem_port_arbiter against a transaction-level model of its arbitration and completion rules.
// Latency: expects the bus one cycle after an IDLE grant, and the ack in the bus_ready cycle.
// Backpressure: requesters hold their request until acked. The bench slave holds bus_ready off for a random number of cycles.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_flush, if_ack;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              mem_req, mem_we, mem_ack;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              bus_req, bus_we, bus_ready;
    logic [3:0]        bus_be;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata, bus_rdata;

    int checks = 0;
    int errors = 0;

    // Model state: outstanding requests and consecutive MEM wins over a waiting fetch.
    bit if_pend, mem_pend;
    int starve;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Who wins the next IDLE arbitration: MEM first, unless fetch has waited out STARVE_MAX MEM wins.
    task automatic arbitrate(output bit pick_if);
        if (FAIR && starve == STARVE_MAX && if_pend) pick_if = 1'b1;
        else pick_if = !mem_pend;
        if (!if_pend || pick_if) starve = 0;
        else starve++;
    endtask

    // Plays the bus slave for one transaction and checks bus fields, hold and ack routing.
    // flush_at: -1 none, 0..dly-1 a hold cycle, dly the bus_ready cycle.
    task automatic serve(input bit exp_if, input int dly, input int flush_at,
                         input bit release_req, input logic [31:0] rd, input string tag);
        int w;
        bit acked;
        logic [ADDR_W-1:0] e_addr;
        logic e_we;
        logic [3:0] e_be;
        logic [31:0] e_wd;
        e_addr = exp_if ? {if_addr[ADDR_W-1:2], 2'b00} : mem_addr;
        e_we   = exp_if ? 1'b0 : mem_we;
        e_be   = exp_if ? 4'hF : mem_be;
        e_wd   = mem_wdata;
        acked  = 1'b1;
        w = 0;
        do begin
            tick;
            w++;
        end while (bus_req !== 1'b1 && w < 20);
        chk({tag, ".bus_req"}, bus_req, 1);
        chk({tag, ".grant_latency"}, w, 1);
        chk({tag, ".bus_addr"}, bus_addr, e_addr);
        chk({tag, ".bus_we"}, bus_we, e_we);
        chk({tag, ".bus_be"}, bus_be, e_be);
        if (!exp_if) chk({tag, ".bus_wdata"}, bus_wdata, e_wd);
        for (int i = 0; i < dly; i++) begin
            tick;
            if_flush = (flush_at == i);
            if (flush_at == i) begin
                if_req = 1'b0;
                if_pend = 1'b0;
                if (exp_if) acked = 1'b0;
            end
            #1;
            chk({tag, ".hold"}, {bus_req, bus_addr, bus_be}, {1'b1, e_addr, e_be});
            chk({tag, ".hold_ack"}, {if_ack, mem_ack}, 0);
        end
        tick;
        if_flush = (flush_at == dly);
        if (flush_at == dly) begin
            if_req = 1'b0;
            if_pend = 1'b0;
            if (exp_if) acked = 1'b0;
        end
        bus_ready = 1'b1;
        bus_rdata = rd;
        #1;
        chk({tag, ".if_ack"}, if_ack, exp_if && acked);
        chk({tag, ".mem_ack"}, mem_ack, !exp_if && acked);
        if (acked) chk({tag, ".rdata"}, exp_if ? if_rdata : mem_rdata, rd);
        tick;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        if_flush  = 1'b0;
        if (release_req) begin
            if (exp_if) begin if_req = 1'b0; if_pend = 1'b0; end
            else begin mem_req = 1'b0; mem_pend = 1'b0; end
        end
        #1;
        chk({tag, ".ack_width"}, {if_ack, mem_ack}, 0);
        chk({tag, ".idle_gap"}, bus_req, 0);
    endtask

    task automatic set_mem(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        mem_we = we; mem_be = be; mem_addr = a; mem_wdata = wd;
        mem_req = 1'b1; mem_pend = 1'b1;
    endtask

    task automatic set_if(input logic [31:0] a);
        if_addr = a; if_req = 1'b1; if_pend = 1'b1;
    endtask

    initial begin
        bit p;
        int dly, fl;
        logic [1:0] k;
        rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_be = 0; mem_addr = 0; mem_wdata = 0;
        bus_ready = 0; bus_rdata = 0;
        if_pend = 0; mem_pend = 0; starve = 0;
        repeat (3) tick;
        chk("reset.bus", {bus_req, bus_we, bus_be, bus_addr, bus_wdata}, 0);
        chk("reset.acks", {if_ack, mem_ack}, 0);
        rst = 1'b0;
        tick;

        // Single fetch, unaligned address.
        set_if(32'h0000_1006);
        arbitrate(p);
        serve(1'b1, 1, -1, 1'b1, 32'hDEAD_BEEF, "fetch");

        // Contention: MEM wins first, then IF.
        set_mem(1'b1, 4'b0011, 32'h0000_2000, 32'h0000_1234);
        set_if(32'h0000_3000);
        arbitrate(p);
        serve(1'b0, 1, -1, 1'b1, 32'h1111_2222, "contend.mem");
        arbitrate(p);
        serve(1'b1, 0, -1, 1'b1, 32'h3333_4444, "contend.if");

        // Flush one cycle before bus_ready drops the fetch; the next fetch is normal.
        set_if(32'h0000_0080);
        arbitrate(p);
        serve(1'b1, 2, 1, 1'b1, 32'h5555_6666, "flush_mid");
        set_if(32'h0000_0040);
        arbitrate(p);
        serve(1'b1, 1, -1, 1'b1, 32'h7777_8888, "after_flush");

        // Flush in the same cycle as bus_ready.
        set_if(32'h0000_0100);
        arbitrate(p);
        serve(1'b1, 1, 1, 1'b1, 32'h0BAD_F00D, "flush_ready");

        // Flush while MEM owns the bus leaves MEM untouched.
        set_mem(1'b0, 4'hF, 32'h0000_4000, 32'h0);
        arbitrate(p);
        serve(1'b0, 2, 1, 1'b1, 32'hCAFE_0001, "flush_mem");

        // Reset during MEM_BUSY together with bus_ready.
        set_mem(1'b0, 4'hF, 32'h0000_5000, 32'h0);
        tick;
        chk("rst_mid.bus_req", bus_req, 1);
        tick;
        rst = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h9999_9999;
        #1;
        chk("rst_mid.no_ack", {if_ack, mem_ack}, 0);
        tick;
        rst = 1'b0; bus_ready = 1'b0;
        #1;
        chk("rst_mid.bus_req_low", bus_req, 0);
        chk("rst_mid.bus_addr_reset", bus_addr, 0);
        starve = 0;
        arbitrate(p);
        serve(1'b0, 1, -1, 1'b1, 32'hABCD_0123, "rst_fresh");

        // Stray bus_ready in IDLE.
        tick;
        bus_ready = 1'b1; bus_rdata = 32'h1357_9BDF;
        #1;
        chk("stray.acks", {if_ack, mem_ack}, 0);
        tick;
        bus_ready = 1'b0;
        #1;
        chk("stray.bus_req", bus_req, 0);
        set_if(32'h0000_0200);
        arbitrate(p);
        serve(1'b1, 0, -1, 1'b1, 32'h2468_ACE0, "stray.after");

        // MEM held continuously while a fetch waits.
        tick;
        starve = 0;
        set_mem(1'b1, 4'b1100, 32'h8000_0600, 32'h00C0_FFEE);
        set_if(32'h0000_0500);
        for (int t = 0; t < 7; t++) begin
            arbitrate(p);
            serve(p, 0, -1, p, $urandom, "fair");
        end
        mem_req = 1'b0; mem_pend = 1'b0;
        if (if_pend) begin
            arbitrate(p);
            serve(1'b1, 0, -1, 1'b1, $urandom, "fair.tail");
        end

        // Random rounds of fetch/MEM traffic with random ready delay and flushes.
        for (int r = 0; r < 30; r++) begin
            tick;
            starve = 0;
            k = 2'($urandom_range(1, 3));
            if (k[1]) set_mem(1'($urandom), 4'($urandom), $urandom | 32'h8000_0000, $urandom);
            if (k[0]) set_if($urandom & 32'h7FFF_FFFF);
            while (if_pend || mem_pend) begin
                arbitrate(p);
                dly = $urandom_range(0, 3);
                fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dly) : -1;
                serve(p, dly, fl, 1'b1, $urandom, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
